mem_access_unit: RTL and testbench

- Memory-stage data-bus access engine, the successor of the combinational memory stage.
- Latches one load/store from execute and owns the dbus transaction with a stable request held until data_ok.
- Aligns and extends read data, buffers the result until writeback accepts it.
- Parametrised in data/address width, with optional misalignment trapping.

---
 rtl/mem_pkg.sv | 36 +++
 rtl/mem_align.sv | 64 ++++++
 rtl/mem_access_unit.sv | 164 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types for the memory-stage access engine: access sizes, FSM states, alignment check.
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
package mem_pkg;

    typedef enum logic [2:0] {
        MSIZE_B = 3'd0,
        MSIZE_H = 3'd1,
        MSIZE_W = 3'd2,
        MSIZE_D = 3'd3
    } msize_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } mau_state_t;

    // An access is misaligned when the address is not a multiple of its size,
    // or when the access is wider than the data bus.
    function automatic logic misaligned(
        input logic [2:0]  addr_lo,
        input logic [2:0]  size,
        input int unsigned data_w
    );
        logic [2:0] mask;
        case (size)
            MSIZE_B: mask = 3'b000;
            MSIZE_H: mask = 3'b001;
            MSIZE_W: mask = 3'b011;
            default: mask = 3'b111;
        endcase
        return ((addr_lo & mask) != 3'b000) || ((32'd8 << size) > data_w);
    endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane alignment: STORE=1 shifts store data into lanes and builds the strobe,
// STORE=0 extracts load data from its lane and sign/zero-extends it.
// Latency: purely combinational. Backpressure: none.
module mem_align
    import mem_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter bit STORE  = 1'b0
) (
    input  logic [DATA_W-1:0]            data_i,
    input  logic [$clog2(DATA_W/8)-1:0]  off_i,
    input  logic [2:0]                   size_i,
    input  logic                         unsigned_i,
    output logic [DATA_W-1:0]            data_o,
    output logic [DATA_W/8-1:0]          strobe_o
);

    localparam int NB = DATA_W / 8;

    if (STORE) begin : g_store
        logic [2*NB-1:0] mask_w;
        logic [2*NB-1:0] mask_sh;
        logic            unused_store;

        assign unused_store = unsigned_i;

        // Byte mask of the access size, shifted to its lane; bytes that fall
        // past the top lane are dropped.
        always_comb begin
            mask_w = '0;
            for (int b = 0; b < NB; b++) begin
                mask_w[b] = (b < (1 << size_i));
            end
            mask_sh  = mask_w << off_i;
            strobe_o = mask_sh[NB-1:0];
            data_o   = data_i << {off_i, 3'b000};
        end
    end else begin : g_load
        logic [DATA_W-1:0] shifted;
        logic              sign_bit;

        // Bring the addressed bytes down to bit 0, then fill above the access
        // width with the sign bit or zeros; full-bus accesses pass unchanged.
        always_comb begin
            shifted = data_i >> {off_i, 3'b000};
            case (size_i)
                MSIZE_B: sign_bit = shifted[7];
                MSIZE_H: sign_bit = shifted[15];
                MSIZE_W: sign_bit = shifted[31];
                default: sign_bit = shifted[DATA_W-1];
            endcase
            data_o = '0;
            for (int i = 0; i < DATA_W; i++) begin
                if (i < (8 << size_i)) begin
                    data_o[i] = shifted[i];
                end else begin
                    data_o[i] = sign_bit & ~unsigned_i;
                end
            end
            strobe_o = '0;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage dbus engine: latches one load/store, holds a frozen request until data_ok, buffers the aligned result.
// Latency: accept at cycle 0, request from cycle 1, result one cycle after data_ok (minimum 2). Optional MEM_MISALIGN_TRAP_EN.
// Backpressure: in_ready only in IDLE or when HOLD retires (out_ready); result held stable until out_ready.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ADDR_W-1:0]    in_addr,
    input  logic [DATA_W-1:0]    in_wdata,
    input  logic [2:0]           in_size,
    input  logic                 in_write,
    input  logic                 in_unsigned,
    output logic                 dreq_valid,
    output logic [ADDR_W-1:0]    dreq_addr,
    output logic [2:0]           dreq_size,
    output logic [DATA_W/8-1:0]  dreq_strobe,
    output logic [DATA_W-1:0]    dreq_data,
    input  logic                 dresp_data_ok,
    input  logic [DATA_W-1:0]    dresp_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_rdata,
    output logic                 out_misalign,
    output logic                 busy
);

    localparam int OFF_W = $clog2(DATA_W / 8);
    localparam int NB    = DATA_W / 8;

    mau_state_t          state_q,        state_d;
    logic [ADDR_W-1:0]   dreq_addr_q,    dreq_addr_d;
    logic [2:0]          dreq_size_q,    dreq_size_d;
    logic [NB-1:0]       dreq_strobe_q,  dreq_strobe_d;
    logic [DATA_W-1:0]   dreq_data_q,    dreq_data_d;
    logic                write_q,        write_d;
    logic                unsigned_q,     unsigned_d;
    logic [DATA_W-1:0]   out_rdata_q,    out_rdata_d;
    logic                out_misalign_q, out_misalign_d;

    logic                accept;
    logic                acc_mis;
    logic [DATA_W-1:0]   st_data;
    logic [NB-1:0]       st_strobe;
    logic [DATA_W-1:0]   ld_data;
    logic [NB-1:0]       ld_strobe_unused;

    assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready);
    assign accept   = in_valid && in_ready;
    assign acc_mis  = misaligned(in_addr[2:0], in_size, DATA_W);

    mem_align #(.DATA_W(DATA_W), .STORE(1'b1)) u_store_align (
        .data_i     (in_wdata),
        .off_i      (in_addr[OFF_W-1:0]),
        .size_i     (in_size),
        .unsigned_i (1'b0),
        .data_o     (st_data),
        .strobe_o   (st_strobe)
    );

    // The load path works on the frozen request so it lines up with the response.
    mem_align #(.DATA_W(DATA_W), .STORE(1'b0)) u_load_align (
        .data_i     (dresp_data),
        .off_i      (dreq_addr_q[OFF_W-1:0]),
        .size_i     (dreq_size_q),
        .unsigned_i (unsigned_q),
        .data_o     (ld_data),
        .strobe_o   (ld_strobe_unused)
    );

    // Next-state and datapath capture; request fields change only on accept,
    // the result only on data_ok in REQ (or a trapped accept).
    always_comb begin
        state_d        = state_q;
        dreq_addr_d    = dreq_addr_q;
        dreq_size_d    = dreq_size_q;
        dreq_strobe_d  = dreq_strobe_q;
        dreq_data_d    = dreq_data_q;
        write_d        = write_q;
        unsigned_d     = unsigned_q;
        out_rdata_d    = out_rdata_q;
        out_misalign_d = out_misalign_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (dresp_data_ok) begin
                    state_d     = ST_HOLD;
                    out_rdata_d = write_q ? '0 : ld_data;
                end
            end
            ST_HOLD: begin
                if (accept) begin
                    state_d = ST_REQ;
                end else if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            dreq_addr_d    = in_addr;
            dreq_size_d    = in_size;
            dreq_strobe_d  = in_write ? st_strobe : '0;
            dreq_data_d    = in_write ? st_data : '0;
            write_d        = in_write;
            unsigned_d     = in_unsigned;
            out_misalign_d = acc_mis;
`ifdef MEM_MISALIGN_TRAP_EN
            // Trapped accesses never reach the bus; report straight away.
            if (acc_mis) begin
                state_d     = ST_HOLD;
                out_rdata_d = '0;
            end
`endif
        end
    end

    // State and datapath registers; reset drops any in-flight transaction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            dreq_addr_q    <= '0;
            dreq_size_q    <= '0;
            dreq_strobe_q  <= '0;
            dreq_data_q    <= '0;
            write_q        <= 1'b0;
            unsigned_q     <= 1'b0;
            out_rdata_q    <= '0;
            out_misalign_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            dreq_addr_q    <= dreq_addr_d;
            dreq_size_q    <= dreq_size_d;
            dreq_strobe_q  <= dreq_strobe_d;
            dreq_data_q    <= dreq_data_d;
            write_q        <= write_d;
            unsigned_q     <= unsigned_d;
            out_rdata_q    <= out_rdata_d;
            out_misalign_q <= out_misalign_d;
        end
    end

    assign dreq_valid   = (state_q == ST_REQ);
    assign dreq_addr    = dreq_addr_q;
    assign dreq_size    = dreq_size_q;
    assign dreq_strobe  = dreq_strobe_q;
    assign dreq_data    = dreq_data_q;
    assign out_valid    = (state_q == ST_HOLD);
    assign out_rdata    = out_rdata_q;
    assign out_misalign = out_misalign_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (64-bit bus): latency, lane alignment, backpressure, misalignment, reset abort.
// Inputs driven and outputs sampled around the falling edge.
// Expectations hand-computed; trap-mode expectations selected by MEM_MISALIGN_TRAP_EN.
module tb_mem_access_unit;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 64;

    logic                clk = 1'b0;
    logic                reset;
    logic                in_valid;
    logic                in_ready;
    logic [ADDR_W-1:0]   in_addr;
    logic [DATA_W-1:0]   in_wdata;
    logic [2:0]          in_size;
    logic                in_write;
    logic                in_unsigned;
    logic                dreq_valid;
    logic [ADDR_W-1:0]   dreq_addr;
    logic [2:0]          dreq_size;
    logic [DATA_W/8-1:0] dreq_strobe;
    logic [DATA_W-1:0]   dreq_data;
    logic                dresp_data_ok;
    logic [DATA_W-1:0]   dresp_data;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_W-1:0]   out_rdata;
    logic                out_misalign;
    logic                busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_addr       (in_addr),
        .in_wdata      (in_wdata),
        .in_size       (in_size),
        .in_write      (in_write),
        .in_unsigned   (in_unsigned),
        .dreq_valid    (dreq_valid),
        .dreq_addr     (dreq_addr),
        .dreq_size     (dreq_size),
        .dreq_strobe   (dreq_strobe),
        .dreq_data     (dreq_data),
        .dresp_data_ok (dresp_data_ok),
        .dresp_data    (dresp_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_rdata     (out_rdata),
        .out_misalign  (out_misalign),
        .busy          (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic [63:0] a, input logic [63:0] wd, input logic [2:0] sz,
                         input logic wr, input logic uns);
        in_valid    = 1'b1;
        in_addr     = a;
        in_wdata    = wd;
        in_size     = sz;
        in_write    = wr;
        in_unsigned = uns;
    endtask

    initial begin
        reset         = 1'b0;
        in_valid      = 1'b0;
        in_addr       = '0;
        in_wdata      = '0;
        in_size       = '0;
        in_write      = 1'b0;
        in_unsigned   = 1'b0;
        dresp_data_ok = 1'b0;
        dresp_data    = '0;
        out_ready     = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_in_ready",     in_ready,     1);
        chk("rst_busy",         busy,         0);
        chk("rst_dreq_valid",   dreq_valid,   0);
        chk("rst_dreq_addr",    dreq_addr,    0);
        chk("rst_dreq_size",    dreq_size,    0);
        chk("rst_dreq_strobe",  dreq_strobe,  0);
        chk("rst_dreq_data",    dreq_data,    0);
        chk("rst_out_valid",    out_valid,    0);
        chk("rst_out_rdata",    out_rdata,    0);
        chk("rst_out_misalign", out_misalign, 0);
        @(negedge clk);
        reset = 1'b1;

        // Signed byte load at offset 3, data_ok in cycle 3 -> out_valid in cycle 4
        @(negedge clk);
        offer(64'h1000_0003, 64'h0, 3'd0, 1'b0, 1'b0);
        #1;
        chk("t1_in_ready_c0", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("t1_dreq_valid_c1", dreq_valid,  1);
        chk("t1_dreq_strobe",   dreq_strobe, 0);
        chk("t1_dreq_addr",     dreq_addr,   64'h1000_0003);
        chk("t1_dreq_size",     dreq_size,   0);
        chk("t1_in_ready_req",  in_ready,    0);
        @(negedge clk);
        #1;
        chk("t1_out_valid_c2", out_valid, 0);
        @(negedge clk);
        dresp_data_ok = 1'b1;
        dresp_data    = 64'h0000_0000_80FF_0000;
        #1;
        chk("t1_out_valid_c3", out_valid, 0);
        @(negedge clk);
        dresp_data_ok = 1'b0;
        dresp_data    = 64'h0;
        out_ready     = 1'b1;
        #1;
        chk("t1_out_valid_c4", out_valid,    1);
        chk("t1_out_rdata",    out_rdata,    64'hFFFF_FFFF_FFFF_FF80);
        chk("t1_out_misalign", out_misalign, 0);
        chk("t1_dreq_valid_c4", dreq_valid,  0);
        chk("t1_in_ready_hold", in_ready,    1);
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        chk("t1_idle_busy", busy,      0);
        chk("t1_idle_oval", out_valid, 0);

        // Half store at offset 6; request frozen across wait cycles while execute offers another
        @(negedge clk);
        offer(64'h2000_0006, 64'hBEEF, 3'd1, 1'b1, 1'b0);
        #1;
        @(negedge clk);
        offer(64'h3000_0001, 64'h1234_5678, 3'd0, 1'b1, 1'b0);
        #1;
        chk("t2_dreq_valid",  dreq_valid,  1);
        chk("t2_dreq_strobe", dreq_strobe, 8'hC0);
        chk("t2_dreq_data",   dreq_data,   64'hBEEF_0000_0000_0000);
        chk("t2_in_ready",    in_ready,    0);
        for (int w = 0; w < 5; w++) begin
            @(negedge clk);
            #1;
            chk("t2_wait_valid",  dreq_valid,  1);
            chk("t2_wait_addr",   dreq_addr,   64'h2000_0006);
            chk("t2_wait_size",   dreq_size,   1);
            chk("t2_wait_strobe", dreq_strobe, 8'hC0);
            chk("t2_wait_data",   dreq_data,   64'hBEEF_0000_0000_0000);
        end
        @(negedge clk);
        in_valid      = 1'b0;
        dresp_data_ok = 1'b1;
        dresp_data    = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        @(negedge clk);
        dresp_data_ok = 1'b0;
        out_ready     = 1'b1;
        #1;
        chk("t2_out_valid", out_valid, 1);
        chk("t2_out_rdata", out_rdata, 0);
        chk("t2_out_mis",   out_misalign, 0);
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        chk("t2_idle_busy", busy, 0);

        // Back-to-back loads, out_ready held, data_ok in first REQ cycle
        @(negedge clk);
        out_ready = 1'b1;
        offer(64'h4000_0008, 64'h0, 3'd3, 1'b0, 1'b0);
        #1;
        @(negedge clk);
        offer(64'h4000_0004, 64'h0, 3'd2, 1'b0, 1'b1);
        dresp_data_ok = 1'b1;
        dresp_data    = 64'h1122_3344_5566_7788;
        #1;
        chk("t3_a_dreq_valid", dreq_valid, 1);
        chk("t3_a_dreq_addr",  dreq_addr,  64'h4000_0008);
        @(negedge clk);
        dresp_data_ok = 1'b0;
        #1;
        chk("t3_a_out_valid", out_valid, 1);
        chk("t3_a_out_rdata", out_rdata, 64'h1122_3344_5566_7788);
        chk("t3_a_in_ready",  in_ready,  1);
        @(negedge clk);
        in_valid      = 1'b0;
        dresp_data_ok = 1'b1;
        dresp_data    = 64'h89AB_CDEF_0123_4567;
        #1;
        chk("t3_b_dreq_valid", dreq_valid, 1);
        chk("t3_b_dreq_addr",  dreq_addr,  64'h4000_0004);
        chk("t3_b_out_valid",  out_valid,  0);
        @(negedge clk);
        dresp_data_ok = 1'b0;
        #1;
        chk("t3_b_out_valid2", out_valid, 1);
        chk("t3_b_out_rdata",  out_rdata, 64'h0000_0000_89AB_CDEF);
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        chk("t3_idle_busy", busy, 0);

        // Writeback stalls 4 cycles in HOLD while execute offers a store; stray data_ok ignored
        @(negedge clk);
        offer(64'h5000_0002, 64'h0, 3'd1, 1'b0, 1'b0);
        #1;
        @(negedge clk);
        offer(64'h5000_0005, 64'hA5, 3'd0, 1'b1, 1'b0);
        dresp_data_ok = 1'b1;
        dresp_data    = 64'h0000_0000_8001_0000;
        #1;
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            dresp_data_ok = 1'b1;
            dresp_data    = 64'hDEAD_BEEF_DEAD_BEEF;
            #1;
            chk("t4_stall_in_ready", in_ready,   0);
            chk("t4_stall_oval",     out_valid,  1);
            chk("t4_stall_rdata",    out_rdata,  64'hFFFF_FFFF_FFFF_8001);
            chk("t4_stall_dreq",     dreq_valid, 0);
        end
        @(negedge clk);
        dresp_data_ok = 1'b0;
        out_ready     = 1'b1;
        #1;
        chk("t4_rel_in_ready", in_ready,  1);
        chk("t4_rel_rdata",    out_rdata, 64'hFFFF_FFFF_FFFF_8001);
        @(negedge clk);
        in_valid      = 1'b0;
        out_ready     = 1'b0;
        dresp_data_ok = 1'b1;
        dresp_data    = 64'h0;
        #1;
        chk("t4_d_dreq_valid",  dreq_valid,  1);
        chk("t4_d_dreq_addr",   dreq_addr,   64'h5000_0005);
        chk("t4_d_dreq_strobe", dreq_strobe, 8'h20);
        chk("t4_d_dreq_data",   dreq_data,   64'h0000_A500_0000_0000);
        @(negedge clk);
        dresp_data_ok = 1'b0;
        out_ready     = 1'b1;
        #1;
        chk("t4_d_out_valid", out_valid, 1);
        chk("t4_d_out_rdata", out_rdata, 0);
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        chk("t4_idle_busy", busy, 0);

        // Misaligned word load at offset 2
        @(negedge clk);
        offer(64'h6000_0002, 64'h0, 3'd2, 1'b0, 1'b0);
        #1;
        @(negedge clk);
        in_valid = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        #1;
        chk("t5_trap_dreq_valid", dreq_valid,   0);
        chk("t5_trap_out_valid",  out_valid,    1);
        chk("t5_trap_misalign",   out_misalign, 1);
        chk("t5_trap_rdata",      out_rdata,    0);
`else
        dresp_data_ok = 1'b1;
        dresp_data    = 64'h1122_3344_5566_7788;
        #1;
        chk("t5_dreq_valid",  dreq_valid,  1);
        chk("t5_dreq_strobe", dreq_strobe, 0);
        chk("t5_out_valid_c1", out_valid,  0);
        @(negedge clk);
        dresp_data_ok = 1'b0;
        #1;
        chk("t5_out_valid", out_valid,    1);
        chk("t5_misalign",  out_misalign, 1);
        chk("t5_rdata",     out_rdata,    64'h0000_0000_3344_5566);
`endif
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        chk("t5_idle_busy", busy, 0);

        // Misaligned word store at offset 6: strobe truncated to the bus (or trapped)
        @(negedge clk);
        offer(64'h7000_0006, 64'h1122_3344, 3'd2, 1'b1, 1'b0);
        #1;
        @(negedge clk);
        in_valid = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        #1;
        chk("t5s_trap_dreq_valid", dreq_valid,   0);
        chk("t5s_trap_out_valid",  out_valid,    1);
        chk("t5s_trap_misalign",   out_misalign, 1);
`else
        dresp_data_ok = 1'b1;
        #1;
        chk("t5s_dreq_valid",  dreq_valid,  1);
        chk("t5s_dreq_strobe", dreq_strobe, 8'hC0);
        chk("t5s_dreq_data",   dreq_data,   64'h3344_0000_0000_0000);
        @(negedge clk);
        dresp_data_ok = 1'b0;
        #1;
        chk("t5s_out_valid", out_valid,    1);
        chk("t5s_misalign",  out_misalign, 1);
        chk("t5s_rdata",     out_rdata,    0);
`endif
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        chk("t5s_idle_busy", busy, 0);

        // Reset asserted mid-REQ aborts the transaction
        @(negedge clk);
        offer(64'h8000_0000, 64'h0, 3'd3, 1'b0, 1'b0);
        #1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("t6_dreq_valid_pre", dreq_valid, 1);
        #1;
        reset = 1'b0;
        #1;
        chk("t6_rst_dreq_valid", dreq_valid, 0);
        chk("t6_rst_out_valid",  out_valid,  0);
        chk("t6_rst_busy",       busy,       0);
        chk("t6_rst_dreq_addr",  dreq_addr,  0);
        @(negedge clk);
        reset         = 1'b1;
        dresp_data_ok = 1'b1;
        dresp_data    = 64'h5555_5555_5555_5555;
        #1;
        chk("t6_post_in_ready", in_ready, 1);
        chk("t6_post_busy",     busy,     0);
        @(negedge clk);
        dresp_data_ok = 1'b0;
        #1;
        chk("t6_post_out_valid", out_valid, 0);
        chk("t6_post_out_rdata", out_rdata, 0);
        chk("t6_post_busy2",     busy,      0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
